num_node_mc_controller: RTL and testbench

Multi-channel successor of the single-lane num-node writer. Monitors NUM_CHANNELS parallel SPMM lanes and captures one num_node value per source-node episode per lane. Buffers captures in per-lane FIFOs and merges them through a round-robin arbiter into the single num_node BRAM write port. Addresses are sequential, with a subgraph-count limit, overflow flags and a synchronous clear. Sits between the SPMM lane array and the num_node BRAM consumed by DMVM/softmax.

---
 rtl/num_node_mc_controller.sv | 187 ++++++++++++++++++
 tb/tb_num_node_mc_controller.sv | 358 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/num_node_mc_controller.sv
// Multi-lane num_node capture: per-lane episode FSMs and FIFOs, merged round-robin into one BRAM write port.
// Optional macro NUM_NODE_CH_TAG_EN prefixes each written value with the granted lane index.
module num_node_mc_controller #(
  parameter int NUM_NODE_WIDTH = 8,
  parameter int NUM_SUBGRAPHS  = 2708,
  parameter int NUM_CHANNELS   = 4,
  parameter int FIFO_DEPTH     = 4,
  localparam int NUM_NODE_ADDR_W = $clog2(NUM_SUBGRAPHS),
  localparam int CH_W            = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   clr_i,
  input  logic [NUM_CHANNELS-1:0]                spmm_vld_i,
  input  logic [NUM_CHANNELS-1:0]                src_flag,
  input  logic [NUM_CHANNELS*NUM_NODE_WIDTH-1:0] num_node,
  output logic [NUM_CHANNELS-1:0]                ch_rdy_o,
  output logic [NUM_CHANNELS-1:0]                overflow_o,
`ifdef NUM_NODE_CH_TAG_EN
  output logic [NUM_NODE_WIDTH+CH_W-1:0]         num_node_bram_din,
`else
  output logic [NUM_NODE_WIDTH-1:0]              num_node_bram_din,
`endif
  output logic                                   num_node_bram_ena,
  output logic [NUM_NODE_ADDR_W-1:0]             num_node_bram_addra,
  output logic                                   done_o
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
`ifdef NUM_NODE_CH_TAG_EN
  localparam int DIN_W = NUM_NODE_WIDTH + CH_W;
`else
  localparam int DIN_W = NUM_NODE_WIDTH;
`endif

  typedef enum logic {IDLE, ARMED} lane_state_e;

  lane_state_e               state_q [NUM_CHANNELS];
  lane_state_e               state_d [NUM_CHANNELS];
  logic [NUM_NODE_WIDTH-1:0] mem_q   [NUM_CHANNELS][FIFO_DEPTH];
  logic [NUM_NODE_WIDTH-1:0] mem_d   [NUM_CHANNELS][FIFO_DEPTH];
  logic [PTR_W-1:0]          wr_q    [NUM_CHANNELS];
  logic [PTR_W-1:0]          wr_d    [NUM_CHANNELS];
  logic [PTR_W-1:0]          rd_q    [NUM_CHANNELS];
  logic [PTR_W-1:0]          rd_d    [NUM_CHANNELS];
  logic [CNT_W-1:0]          cnt_q   [NUM_CHANNELS];
  logic [CNT_W-1:0]          cnt_d   [NUM_CHANNELS];

  logic [NUM_CHANNELS-1:0]    ovf_q, ovf_d, full;
  logic [NUM_NODE_ADDR_W-1:0] addr_q, addr_d, addra_q, addra_d;
  logic [CH_W-1:0]            rr_q, rr_d, gnt;
  logic [DIN_W-1:0]           din_q, din_d;
  logic                       ena_q, ena_d, done_q, done_d;
  logic                       rdy_en_q, rdy_en_d;
  logic                       grant;

  always_comb begin
    for (int unsigned i = 0; i < NUM_CHANNELS; i++) begin
      full[i] = (cnt_q[i] == CNT_W'(FIFO_DEPTH));
    end
  end

  // ch_rdy_o is held low until the first edge after reset release.
  assign ch_rdy_o            = ~full & {NUM_CHANNELS{rdy_en_q}};
  assign overflow_o          = ovf_q;
  assign num_node_bram_din   = din_q;
  assign num_node_bram_ena   = ena_q;
  assign num_node_bram_addra = addra_q;
  assign done_o              = done_q;

  always_comb begin
    state_d  = state_q;
    mem_d    = mem_q;
    wr_d     = wr_q;
    rd_d     = rd_q;
    cnt_d    = cnt_q;
    ovf_d    = ovf_q;
    addr_d   = addr_q;
    addra_d  = addra_q;
    rr_d     = rr_q;
    din_d    = din_q;
    ena_d    = 1'b0;
    done_d   = done_q;
    rdy_en_d = 1'b1;
    grant    = 1'b0;
    gnt      = '0;

    for (int unsigned k = 0; k < NUM_CHANNELS; k++) begin
      int unsigned idx;
      idx = (int'(rr_q) + k) % NUM_CHANNELS;
      if (!grant && cnt_q[idx] != '0) begin
        grant = 1'b1;
        gnt   = CH_W'(idx);
      end
    end
    grant = grant && !done_q;

    for (int unsigned i = 0; i < NUM_CHANNELS; i++) begin
      logic push_ok, pop;
      push_ok = 1'b0;
      pop     = grant && (gnt == CH_W'(i));
      case (state_q[i])
        IDLE: if (src_flag[i] && spmm_vld_i[i]) begin
          state_d[i] = ARMED;
          // Full is judged on the pre-pop count, so a same-cycle pop does not save the capture.
          if (full[i]) begin
            ovf_d[i] = 1'b1;
          end else begin
            push_ok = 1'b1;
            mem_d[i][wr_q[i]] = num_node[i*NUM_NODE_WIDTH +: NUM_NODE_WIDTH];
            wr_d[i] = wr_q[i] + 1'b1;
          end
        end
        ARMED: if (!src_flag[i] && spmm_vld_i[i]) state_d[i] = IDLE;
        default: state_d[i] = IDLE;
      endcase
      if (pop) rd_d[i] = rd_q[i] + 1'b1;
      if (push_ok && !pop)      cnt_d[i] = cnt_q[i] + 1'b1;
      else if (!push_ok && pop) cnt_d[i] = cnt_q[i] - 1'b1;
    end

    if (grant) begin
      ena_d   = 1'b1;
`ifdef NUM_NODE_CH_TAG_EN
      din_d   = {gnt, mem_q[gnt][rd_q[gnt]]};
`else
      din_d   = mem_q[gnt][rd_q[gnt]];
`endif
      addra_d = addr_q;
      if (addr_q == NUM_NODE_ADDR_W'(NUM_SUBGRAPHS - 1)) done_d = 1'b1;
      else addr_d = addr_q + 1'b1;
      rr_d = (gnt == CH_W'(NUM_CHANNELS - 1)) ? '0 : gnt + 1'b1;
    end

    if (clr_i) begin
      for (int unsigned i = 0; i < NUM_CHANNELS; i++) begin
        state_d[i] = IDLE;
        wr_d[i]    = '0;
        rd_d[i]    = '0;
        cnt_d[i]   = '0;
      end
      ovf_d   = '0;
      addr_d  = '0;
      addra_d = '0;
      rr_d    = '0;
      din_d   = '0;
      ena_d   = 1'b0;
      done_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_CHANNELS; i++) begin
        state_q[i] <= IDLE;
        wr_q[i]    <= '0;
        rd_q[i]    <= '0;
        cnt_q[i]   <= '0;
        for (int unsigned j = 0; j < FIFO_DEPTH; j++) mem_q[i][j] <= '0;
      end
      ovf_q    <= '0;
      addr_q   <= '0;
      addra_q  <= '0;
      rr_q     <= '0;
      din_q    <= '0;
      ena_q    <= 1'b0;
      done_q   <= 1'b0;
      rdy_en_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      mem_q    <= mem_d;
      wr_q     <= wr_d;
      rd_q     <= rd_d;
      cnt_q    <= cnt_d;
      ovf_q    <= ovf_d;
      addr_q   <= addr_d;
      addra_q  <= addra_d;
      rr_q     <= rr_d;
      din_q    <= din_d;
      ena_q    <= ena_d;
      done_q   <= done_d;
      rdy_en_q <= rdy_en_d;
    end
  end

endmodule

// File: tb/tb_num_node_mc_controller.sv
// Directed bench for num_node_mc_controller: 4 lanes, depth-4 FIFOs, 5-entry subgraph limit.
module tb_num_node_mc_controller;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clr_i = 1'b0;
  logic [3:0]  spmm_vld_i = '0;
  logic [3:0]  src_flag = '0;
  logic [31:0] num_node = '0;
  logic [3:0]  ch_rdy_o, overflow_o;
`ifdef NUM_NODE_CH_TAG_EN
  logic [9:0]  num_node_bram_din;
`else
  logic [7:0]  num_node_bram_din;
`endif
  logic        num_node_bram_ena;
  logic [2:0]  num_node_bram_addra;
  logic        done_o;
  logic [7:0]  din_v;

  int tests_run = 0;
  int fails = 0;

  assign din_v = num_node_bram_din[7:0];

  num_node_mc_controller #(
    .NUM_NODE_WIDTH(8),
    .NUM_SUBGRAPHS(5),
    .NUM_CHANNELS(4),
    .FIFO_DEPTH(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .clr_i(clr_i),
    .spmm_vld_i(spmm_vld_i),
    .src_flag(src_flag),
    .num_node(num_node),
    .ch_rdy_o(ch_rdy_o),
    .overflow_o(overflow_o),
    .num_node_bram_din(num_node_bram_din),
    .num_node_bram_ena(num_node_bram_ena),
    .num_node_bram_addra(num_node_bram_addra),
    .done_o(done_o)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_lane(input int ch, input logic s, input logic v, input logic [7:0] val);
    src_flag[ch]   = s;
    spmm_vld_i[ch] = v;
    num_node[ch*8 +: 8] = val;
  endtask

  task automatic idle_in();
    spmm_vld_i = '0;
    src_flag   = '0;
  endtask

  task automatic end_all();
    spmm_vld_i = 4'hF;
    src_flag   = '0;
    tick();
    idle_in();
  endtask

  task automatic do_clear();
    clr_i = 1'b1;
    tick();
    clr_i = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    tests_run++;
    if ({num_node_bram_ena, done_o, ch_rdy_o, overflow_o, din_v, num_node_bram_addra} !== '0) begin
      fails++;
      $display("FAIL reset_outputs: ena=%0b done=%0b rdy=%b ovf=%b din=%0d addra=%0d, want all 0",
               num_node_bram_ena, done_o, ch_rdy_o, overflow_o, din_v, num_node_bram_addra);
    end
    tick();
    rst = 1'b0;
    tick();
    tests_run++;
    if (ch_rdy_o !== 4'b1111) begin
      fails++;
      $display("FAIL reset_release_rdy: got %b want 1111", ch_rdy_o);
    end
  endtask

  task automatic test_single_lane();
    set_lane(0, 1'b1, 1'b1, 8'd37);
    tick();
    idle_in();
    tests_run++;
    if (num_node_bram_ena !== 1'b0) begin
      fails++;
      $display("FAIL single_early: ena=%0b want 0 one edge after capture", num_node_bram_ena);
    end
    tick();
    tests_run++;
    if (num_node_bram_ena !== 1'b1 || din_v !== 8'd37 || num_node_bram_addra !== 3'd0) begin
      fails++;
      $display("FAIL single_write: ena=%0b din=%0d addra=%0d want 1/37/0",
               num_node_bram_ena, din_v, num_node_bram_addra);
    end
    set_lane(0, 1'b1, 1'b1, 8'd99);
    tick();
    idle_in();
    for (int c = 0; c < 3; c++) begin
      tick();
      tests_run++;
      if (num_node_bram_ena !== 1'b0 || num_node_bram_addra !== 3'd0) begin
        fails++;
        $display("FAIL single_armed_ignore: ena=%0b addra=%0d want 0/0", num_node_bram_ena, num_node_bram_addra);
      end
    end
    end_all();
  endtask

  task automatic test_contention();
    do_clear();
    for (int i = 0; i < 4; i++) set_lane(i, 1'b1, 1'b1, 8'(10 + i));
    tick();
    end_all();
    tests_run++;
    if (num_node_bram_ena !== 1'b1 || din_v !== 8'd10 || num_node_bram_addra !== 3'd0) begin
      fails++;
      $display("FAIL contention_w0: ena=%0b din=%0d addra=%0d want 1/10/0",
               num_node_bram_ena, din_v, num_node_bram_addra);
    end
    for (int k = 1; k < 4; k++) begin
      tick();
      tests_run++;
      if (num_node_bram_ena !== 1'b1 || din_v !== 8'(10 + k) || num_node_bram_addra !== 3'(k)) begin
        fails++;
        $display("FAIL contention_w%0d: ena=%0b din=%0d addra=%0d want 1/%0d/%0d",
                 k, num_node_bram_ena, din_v, num_node_bram_addra, 10 + k, k);
      end
    end
    tick();
    tests_run++;
    if (num_node_bram_ena !== 1'b0) begin
      fails++;
      $display("FAIL contention_quiet: ena=%0b want 0", num_node_bram_ena);
    end
    // RR pointer should be back at 0: lane 0 beats lane 1 for the last slot.
    set_lane(0, 1'b1, 1'b1, 8'd14);
    set_lane(1, 1'b1, 1'b1, 8'd15);
    tick();
    end_all();
    tests_run++;
    if (num_node_bram_ena !== 1'b1 || din_v !== 8'd14 || num_node_bram_addra !== 3'd4 || done_o !== 1'b1) begin
      fails++;
      $display("FAIL contention_rr0: ena=%0b din=%0d addra=%0d done=%0b want 1/14/4/1",
               num_node_bram_ena, din_v, num_node_bram_addra, done_o);
    end
  endtask

  task automatic test_rr_fairness();
    logic [7:0] exp_din [4];
    exp_din = '{8'd63, 8'd61, 8'd73, 8'd71};
    do_clear();
    set_lane(1, 1'b1, 1'b1, 8'd50);
    tick();
    idle_in();
    set_lane(1, 1'b0, 1'b1, 8'd0);
    tick();
    idle_in();
    set_lane(1, 1'b1, 1'b1, 8'd61);
    set_lane(3, 1'b1, 1'b1, 8'd63);
    tick();
    end_all();
    for (int k = 0; k < 4; k++) begin
      if (k == 0) begin
        set_lane(1, 1'b1, 1'b1, 8'd71);
        set_lane(3, 1'b1, 1'b1, 8'd73);
      end
      if (k == 1) begin
        spmm_vld_i = 4'hF;
        src_flag   = '0;
      end
      if (k >= 2) idle_in();
      tests_run++;
      if (num_node_bram_ena !== 1'b1 || din_v !== exp_din[k] || num_node_bram_addra !== 3'(k + 1)) begin
        fails++;
        $display("FAIL rr_grant%0d: ena=%0b din=%0d addra=%0d want 1/%0d/%0d",
                 k, num_node_bram_ena, din_v, num_node_bram_addra, exp_din[k], k + 1);
      end
      tick();
    end
    idle_in();
    tests_run++;
    if (done_o !== 1'b1 || num_node_bram_ena !== 1'b0) begin
      fails++;
      $display("FAIL rr_done: done=%0b ena=%0b want 1/0", done_o, num_node_bram_ena);
    end
  endtask

  task automatic test_limit();
    do_clear();
    for (int i = 0; i < 4; i++) set_lane(i, 1'b1, 1'b1, 8'(20 + i));
    tick();
    end_all();
    set_lane(0, 1'b1, 1'b1, 8'd24);
    set_lane(1, 1'b1, 1'b1, 8'd25);
    tick();
    end_all();
    tick();
    tests_run++;
    if (num_node_bram_ena !== 1'b1 || din_v !== 8'd23 || num_node_bram_addra !== 3'd3 || done_o !== 1'b0) begin
      fails++;
      $display("FAIL limit_w3: ena=%0b din=%0d addra=%0d done=%0b want 1/23/3/0",
               num_node_bram_ena, din_v, num_node_bram_addra, done_o);
    end
    tick();
    tests_run++;
    if (num_node_bram_ena !== 1'b1 || din_v !== 8'd24 || num_node_bram_addra !== 3'd4 || done_o !== 1'b1) begin
      fails++;
      $display("FAIL limit_last: ena=%0b din=%0d addra=%0d done=%0b want 1/24/4/1",
               num_node_bram_ena, din_v, num_node_bram_addra, done_o);
    end
    for (int c = 0; c < 3; c++) begin
      tick();
      tests_run++;
      if (num_node_bram_ena !== 1'b0 || num_node_bram_addra !== 3'd4 || din_v !== 8'd24 || done_o !== 1'b1) begin
        fails++;
        $display("FAIL limit_hold: ena=%0b din=%0d addra=%0d done=%0b want 0/24/4/1",
                 num_node_bram_ena, din_v, num_node_bram_addra, done_o);
      end
    end
  endtask

  task automatic test_overflow();
    for (int e = 0; e < 5; e++) begin
      set_lane(2, 1'b1, 1'b1, 8'(80 + e));
      tick();
      set_lane(2, 1'b0, 1'b1, 8'd0);
      tick();
      idle_in();
      if (e == 3) begin
        tests_run++;
        if (ch_rdy_o !== 4'b1011 || overflow_o !== 4'b0000) begin
          fails++;
          $display("FAIL overflow_full: rdy=%b ovf=%b want 1011/0000", ch_rdy_o, overflow_o);
        end
      end
    end
    tests_run++;
    if (overflow_o !== 4'b0100 || ch_rdy_o !== 4'b1011 || num_node_bram_ena !== 1'b0) begin
      fails++;
      $display("FAIL overflow_drop: ovf=%b rdy=%b ena=%0b want 0100/1011/0",
               overflow_o, ch_rdy_o, num_node_bram_ena);
    end
  endtask

  task automatic test_async_reset();
    set_lane(0, 1'b1, 1'b1, 8'd90);
    set_lane(3, 1'b1, 1'b1, 8'd93);
    tick();
    idle_in();
    rst = 1'b1;
    #1;
    tests_run++;
    if ({num_node_bram_ena, done_o, ch_rdy_o, overflow_o, din_v, num_node_bram_addra} !== '0) begin
      fails++;
      $display("FAIL async_reset: ena=%0b done=%0b rdy=%b ovf=%b din=%0d addra=%0d want all 0",
               num_node_bram_ena, done_o, ch_rdy_o, overflow_o, din_v, num_node_bram_addra);
    end
    tick();
    tick();
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      tests_run++;
      if (num_node_bram_ena !== 1'b0 || ch_rdy_o !== 4'b1111) begin
        fails++;
        $display("FAIL reset_no_write: ena=%0b rdy=%b want 0/1111", num_node_bram_ena, ch_rdy_o);
      end
    end
    set_lane(3, 1'b1, 1'b1, 8'd99);
    tick();
    idle_in();
    tick();
    tests_run++;
    if (num_node_bram_ena !== 1'b1 || din_v !== 8'd99 || num_node_bram_addra !== 3'd0) begin
      fails++;
      $display("FAIL reset_first_write: ena=%0b din=%0d addra=%0d want 1/99/0",
               num_node_bram_ena, din_v, num_node_bram_addra);
    end
    end_all();
  endtask

  task automatic test_clear();
    do_clear();
    for (int i = 0; i < 3; i++) set_lane(i, 1'b1, 1'b1, 8'(40 + i));
    tick();
    idle_in();
    tick();
    tests_run++;
    if (num_node_bram_ena !== 1'b1 || din_v !== 8'd40 || num_node_bram_addra !== 3'd0) begin
      fails++;
      $display("FAIL clear_pre: ena=%0b din=%0d addra=%0d want 1/40/0",
               num_node_bram_ena, din_v, num_node_bram_addra);
    end
    clr_i = 1'b1;
    #2;
    tests_run++;
    if (num_node_bram_ena !== 1'b1) begin
      fails++;
      $display("FAIL clear_sync: ena=%0b want 1 before the clearing edge", num_node_bram_ena);
    end
    tick();
    clr_i = 1'b0;
    tests_run++;
    if ({num_node_bram_ena, done_o, overflow_o, din_v, num_node_bram_addra} !== '0 || ch_rdy_o !== 4'b1111) begin
      fails++;
      $display("FAIL clear_outputs: ena=%0b done=%0b ovf=%b din=%0d addra=%0d rdy=%b want 0/0/0000/0/0/1111",
               num_node_bram_ena, done_o, overflow_o, din_v, num_node_bram_addra, ch_rdy_o);
    end
    for (int c = 0; c < 2; c++) begin
      tick();
      tests_run++;
      if (num_node_bram_ena !== 1'b0) begin
        fails++;
        $display("FAIL clear_no_write: ena=%0b want 0", num_node_bram_ena);
      end
    end
    set_lane(1, 1'b1, 1'b1, 8'd55);
    tick();
    idle_in();
    tick();
    tests_run++;
    if (num_node_bram_ena !== 1'b1 || din_v !== 8'd55 || num_node_bram_addra !== 3'd0) begin
      fails++;
      $display("FAIL clear_first_write: ena=%0b din=%0d addra=%0d want 1/55/0",
               num_node_bram_ena, din_v, num_node_bram_addra);
    end
  endtask

  initial begin
    test_reset();
    test_single_lane();
    test_contention();
    test_rr_fairness();
    test_limit();
    test_overflow();
    test_async_reset();
    test_clear();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
